// File: rtl/max7219_frame_sequencer.sv
// MAX7219 chain driver: runs the device init sequence after reset, then refreshes the eight
// digit rows from a snapshot of the pattern generator's word array. Intensity changes are
// inserted as a broadcast write between frames.
module max7219_frame_sequencer #(
  parameter int unsigned DISP_ROWS      = 1,
  parameter int unsigned DISP_COLUMNS   = 1,
  parameter int unsigned CLK_DIV        = 4,
  parameter logic [3:0]  INIT_INTENSITY = 4'h8
) (
  input  logic                                             i_Clk,
  input  logic                                             i_Rst_n,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_DataStream,
  input  logic                                             i_Enable,
  input  logic [3:0]                                       i_Intensity,
  output logic                                             o_SPI_Clk,
  output logic                                             o_SPI_Mosi,
  output logic                                             o_SPI_Cs_n,
  output logic                                             o_Busy,
  output logic                                             o_FrameDone,
  output logic                                             o_InitDone
);

  localparam int unsigned N    = DISP_ROWS * DISP_COLUMNS;
  localparam int unsigned W    = 16 * N;
  localparam int unsigned BitW = $clog2(W + 1);
  localparam int unsigned DivW = $clog2(CLK_DIV + 1);

  typedef logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] frame_t;

  typedef enum logic [1:0] {StInit, StIntenUpd, StFrame, StIdle} state_e;
  typedef enum logic [2:0] {PhIdle, PhLow, PhHigh, PhTail, PhGap1, PhGap2} phase_e;

  state_e          st_q, st_d;
  phase_e          ph_q, ph_d;
  logic [2:0]      step_q, step_d, step_nxt;
  logic [DivW-1:0] div_q, div_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [W-1:0]    shift_q, shift_d;
  frame_t          frame_q, frame_d;
  logic [3:0]      int_q, int_d;
  logic            sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic            done_q, done_d, init_done_q, init_done_d;

  logic            div_end, gap_end, start, frame_boundary, frame_entry, begin_frame;
  logic [W-1:0]    load;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h0F00;
      3'd1:    return 16'h0B07;
      3'd2:    return 16'h0900;
      3'd3:    return {12'h0A0, INIT_INTENSITY};
      default: return 16'h0C01;
    endcase
  endfunction

  assign step_nxt = step_q + 3'd1;
  assign div_end  = (div_q == DivW'(CLK_DIV - 1));
  assign gap_end  = (ph_q == PhGap2) && div_end;

  // Bit engine plus sequencer: decides the next transaction at each gap end.
  always_comb begin
    st_d           = st_q;
    ph_d           = ph_q;
    step_d         = step_q;
    div_d          = div_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    frame_d        = frame_q;
    int_d          = int_q;
    sck_d          = sck_q;
    mosi_d         = mosi_q;
    cs_n_d         = cs_n_q;
    done_d         = 1'b0;
    init_done_d    = init_done_q;
    start          = 1'b0;
    load           = '0;
    frame_boundary = 1'b0;
    frame_entry    = 1'b0;
    begin_frame    = 1'b0;

    if (ph_q != PhIdle) div_d = div_end ? '0 : div_q + DivW'(1);

    unique case (ph_q)
      PhLow: if (div_end) begin
        ph_d  = PhHigh;
        sck_d = 1'b1;
      end
      PhHigh: if (div_end) begin
        sck_d   = 1'b0;
        shift_d = shift_q << 1;
        mosi_d  = shift_q[W-2];
        if (bit_q == BitW'(W - 1)) begin
          ph_d = PhTail;
        end else begin
          ph_d  = PhLow;
          bit_d = bit_q + BitW'(1);
        end
      end
      PhTail: if (div_end) begin
        ph_d   = PhGap1;
        cs_n_d = 1'b1;
        if (st_q == StFrame && step_q == 3'd7) done_d = 1'b1;
      end
      PhGap1: if (div_end) ph_d = PhGap2;
      PhGap2: if (div_end) ph_d = PhIdle;
      default: ;
    endcase

    unique case (st_q)
      StInit: begin
        if (ph_q == PhIdle) begin
          start = 1'b1;
          load  = {N{init_word(step_q)}};
        end else if (gap_end) begin
          if (step_q != 3'd4) begin
            step_d = step_nxt;
            start  = 1'b1;
            load   = {N{init_word(step_nxt)}};
          end else begin
            init_done_d    = 1'b1;
            frame_boundary = 1'b1;
          end
        end
      end
      StFrame: if (gap_end) begin
        if (step_q != 3'd7) begin
          step_d = step_nxt;
          start  = 1'b1;
          load   = frame_q[step_nxt];
        end else begin
          frame_boundary = 1'b1;
        end
      end
      StIntenUpd: if (gap_end) begin_frame = 1'b1;
      StIdle:     if (i_Enable) frame_entry = 1'b1;
      default: ;
    endcase

    if (frame_boundary) begin
      if (i_Enable) frame_entry = 1'b1;
      else st_d = StIdle;
    end

    // Intensity is only compared here, so it changes strictly between frames.
    if (frame_entry) begin
      if (i_Intensity != int_q) begin
        st_d  = StIntenUpd;
        int_d = i_Intensity;
        start = 1'b1;
        load  = {N{4'h0, 4'hA, 4'h0, i_Intensity}};
      end else begin
        begin_frame = 1'b1;
      end
    end

    // Row 0 is loaded straight from the input since the snapshot lands on the same edge.
    if (begin_frame) begin
      st_d    = StFrame;
      step_d  = 3'd0;
      frame_d = i_DataStream;
      start   = 1'b1;
      load    = i_DataStream[0];
    end

    if (start) begin
      shift_d = load;
      ph_d    = PhLow;
      div_d   = '0;
      bit_d   = '0;
      cs_n_d  = 1'b0;
      sck_d   = 1'b0;
      mosi_d  = load[W-1];
    end
  end

  // State and registered SPI outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      st_q        <= StInit;
      ph_q        <= PhIdle;
      step_q      <= 3'd0;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_q     <= '0;
      int_q       <= INIT_INTENSITY;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      step_q      <= step_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      int_q       <= int_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_SPI_Clk   = sck_q;
  assign o_SPI_Mosi  = mosi_q;
  assign o_SPI_Cs_n  = cs_n_q;
  assign o_Busy      = (ph_q != PhIdle);
  assign o_FrameDone = done_q;
  assign o_InitDone  = init_done_q;

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Directed bench for max7219_frame_sequencer with a 1x2 chain and CLK_DIV=2.
module tb_max7219_frame_sequencer;

  localparam int LowLen = 130;  // 2 * (32*2 + 1)
  localparam int GapLen = 4;    // 2 * 2

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] inten = 4'h8;
  logic [0:7][0:0][1:0][15:0] ds = '0;
  logic sck, mosi, cs_n, busy, fd, init_done;

  int total = 0;
  int bad = 0;

  max7219_frame_sequencer #(
    .DISP_ROWS(1),
    .DISP_COLUMNS(2),
    .CLK_DIV(2),
    .INIT_INTENSITY(4'h8)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_DataStream(ds),
    .i_Enable(en),
    .i_Intensity(inten),
    .o_SPI_Clk(sck),
    .o_SPI_Mosi(mosi),
    .o_SPI_Cs_n(cs_n),
    .o_Busy(busy),
    .o_FrameDone(fd),
    .o_InitDone(init_done)
  );

  always #5 clk = ~clk;

  // SPI chain model: decodes each CS-low window into one 32-bit record.
  logic [31:0] words[$];
  int lens[$];
  int nbits[$];
  int gaps[$];
  int fd_at[$];
  bit in_tx = 1'b0;
  bit prev_sck = 1'b0;
  int cnt = 0, nb = 0, hcnt = 0;
  logic [31:0] sh = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_tx = 1'b0;
      hcnt  = 0;
    end else begin
      if (in_tx) begin
        if (cs_n) begin
          words.push_back(sh);
          lens.push_back(cnt);
          nbits.push_back(nb);
          in_tx = 1'b0;
          hcnt  = 1;
        end else begin
          cnt++;
          if (sck && !prev_sck) begin
            sh = {sh[30:0], mosi};
            nb++;
          end
        end
      end else if (!cs_n) begin
        in_tx = 1'b1;
        gaps.push_back(hcnt);
        cnt = 1;
        nb  = 0;
        sh  = '0;
      end else begin
        hcnt++;
      end
      if (fd) fd_at.push_back(words.size());
    end
    prev_sck = sck;
  end

  function automatic logic [31:0] get_w(input int i);
    if (i < words.size()) return words[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int get_fd(input int i);
    if (i < fd_at.size()) return fd_at[i];
    return -1;
  endfunction

  function automatic logic [31:0] exp_row(input int s, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'(s + 1);
    return {r, b, r, a};
  endfunction

  task automatic set_data(input logic [7:0] a, input logic [7:0] b);
    for (int s = 0; s < 8; s++) begin
      ds[s][0][0] = {8'(s + 1), a};
      ds[s][0][1] = {8'(s + 1), b};
    end
  endtask

  task automatic wait_recs(input int n, input int budget, output bit ok);
    int c = 0;
    while (words.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (words.size() >= n);
  endtask

  task automatic wait_in_tx(input int n, input int budget, output bit ok);
    int c = 0;
    while (!(words.size() >= n && !cs_n) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (words.size() >= n && !cs_n);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sck, mosi, cs_n, busy, fd, init_done} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 001000", {sck, mosi, cs_n, busy, fd, init_done});
    end
  endtask

  task automatic test_init;
    logic [31:0] exp[5];
    int c = 0;
    int n_at_done;
    exp[0] = 32'h0F00_0F00;
    exp[1] = 32'h0B07_0B07;
    exp[2] = 32'h0900_0900;
    exp[3] = 32'h0A08_0A08;
    exp[4] = 32'h0C01_0C01;
    @(negedge clk); #1 rst_n = 1'b1;
    while (!init_done && c < 1500) begin
      @(posedge clk); #1;
      c++;
    end
    n_at_done = words.size();
    total++;
    if (!init_done || n_at_done != 5) begin
      bad++;
      $display("FAIL init_done: done=%0b records=%0d want done=1 records=5", init_done, n_at_done);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (get_w(k) !== exp[k] || lens[k] != LowLen || nbits[k] != 32) begin
        bad++;
        $display("FAIL init_word%0d: got %h len %0d bits %0d want %h len %0d bits 32",
                 k, get_w(k), lens[k], nbits[k], exp[k], LowLen);
      end
    end
    for (int k = 1; k < 5; k++) begin
      total++;
      if (gaps[k] != GapLen) begin
        bad++;
        $display("FAIL init_gap%0d: got %0d want %0d", k, gaps[k], GapLen);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || cs_n !== 1'b1 || words.size() != 5) begin
      bad++;
      $display("FAIL idle_after_init: busy=%b cs_n=%b records=%0d want 0 1 5",
               busy, cs_n, words.size());
    end
  endtask

  int fb;

  task automatic test_frames;
    bit ok;
    fb = words.size();
    set_data(8'hAA, 8'hBB);
    en = 1'b1;
    wait_recs(fb + 8, 8 * 140 + 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL frame_timeout: records=%0d want %0d", words.size(), fb + 8);
    end
    for (int s = 0; s < 8; s++) begin
      total++;
      if (get_w(fb + s) !== exp_row(s, 8'hAA, 8'hBB)) begin
        bad++;
        $display("FAIL frame_row%0d: got %h want %h", s, get_w(fb + s), exp_row(s, 8'hAA, 8'hBB));
      end
    end
    total++;
    if (fd_at.size() != 1 || get_fd(0) != fb + 8) begin
      bad++;
      $display("FAIL frame_done: pulses=%0d at=%0d want 1 at %0d", fd_at.size(), get_fd(0), fb + 8);
    end
  endtask

  task automatic test_snapshot;
    bit ok;
    wait_in_tx(fb + 11, 1000, ok);
    set_data(8'hCC, 8'hDD);
    wait_recs(fb + 24, 14 * 140, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL snapshot_timeout: records=%0d want %0d", words.size(), fb + 24);
    end
    for (int s = 0; s < 8; s++) begin
      total++;
      if (get_w(fb + 8 + s) !== exp_row(s, 8'hAA, 8'hBB)) begin
        bad++;
        $display("FAIL snapshot_old_row%0d: got %h want %h", s, get_w(fb + 8 + s),
                 exp_row(s, 8'hAA, 8'hBB));
      end
      total++;
      if (get_w(fb + 16 + s) !== exp_row(s, 8'hCC, 8'hDD)) begin
        bad++;
        $display("FAIL snapshot_new_row%0d: got %h want %h", s, get_w(fb + 16 + s),
                 exp_row(s, 8'hCC, 8'hDD));
      end
    end
  endtask

  task automatic test_intensity;
    bit ok;
    wait_in_tx(fb + 26, 1000, ok);
    inten = 4'h3;
    wait_recs(fb + 42, 17 * 140, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL inten_timeout: records=%0d want %0d", words.size(), fb + 42);
    end
    total++;
    if (get_w(fb + 31) !== exp_row(7, 8'hCC, 8'hDD) || get_w(fb + 32) !== 32'h0A03_0A03) begin
      bad++;
      $display("FAIL inten_update: got %h %h want %h 0a030a03", get_w(fb + 31), get_w(fb + 32),
               exp_row(7, 8'hCC, 8'hDD));
    end
    total++;
    if (get_w(fb + 33) !== exp_row(0, 8'hCC, 8'hDD) || get_w(fb + 41) !== exp_row(0, 8'hCC, 8'hDD))
    begin
      bad++;
      $display("FAIL inten_no_repeat: got %h %h want %h", get_w(fb + 33), get_w(fb + 41),
               exp_row(0, 8'hCC, 8'hDD));
    end
    total++;
    if (gaps[fb + 32] != GapLen || gaps[fb + 33] != GapLen) begin
      bad++;
      $display("FAIL inten_gaps: got %0d %0d want %0d", gaps[fb + 32], gaps[fb + 33], GapLen);
    end
    total++;
    if (get_fd(3) != fb + 32 || get_fd(4) != fb + 41) begin
      bad++;
      $display("FAIL inten_frame_done: got %0d %0d want %0d %0d", get_fd(3), get_fd(4),
               fb + 32, fb + 41);
    end
  endtask

  task automatic test_disable;
    bit ok;
    int c = 0;
    int viol = 0;
    int n0;
    wait_in_tx(fb + 43, 1000, ok);
    en = 1'b0;
    while (!(busy === 1'b0 && words.size() >= fb + 44) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    n0 = words.size();
    total++;
    if (n0 != fb + 49 || busy !== 1'b0 || fd_at[fd_at.size() - 1] != fb + 49) begin
      bad++;
      $display("FAIL disable_completes: records=%0d busy=%b last_fd=%0d want %0d 0 %0d",
               n0, busy, fd_at[fd_at.size() - 1], fb + 49, fb + 49);
    end
    for (int s = 2; s < 8; s++) begin
      total++;
      if (get_w(fb + 41 + s) !== exp_row(s, 8'hCC, 8'hDD)) begin
        bad++;
        $display("FAIL disable_row%0d: got %h want %h", s, get_w(fb + 41 + s),
                 exp_row(s, 8'hCC, 8'hDD));
      end
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (cs_n !== 1'b1 || busy !== 1'b0 || sck !== 1'b0) viol++;
    end
    total++;
    if (viol != 0 || words.size() != n0) begin
      bad++;
      $display("FAIL idle_quiet: violations=%0d records=%0d want 0 %0d", viol, words.size(), n0);
    end
    en = 1'b1;
    wait_recs(n0 + 1, 400, ok);
    total++;
    if (get_w(n0) !== exp_row(0, 8'hCC, 8'hDD) || init_done !== 1'b1) begin
      bad++;
      $display("FAIL reenable: got %h init_done=%b want %h 1", get_w(n0), init_done,
               exp_row(0, 8'hCC, 8'hDD));
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int c = 0;
    int r;
    while (!(cs_n === 1'b0 && sck === 1'b1) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sck, mosi, cs_n, busy, fd, init_done} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_async: got %b want 001000", {sck, mosi, cs_n, busy, fd, init_done});
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    r = words.size();
    wait_recs(r + 1, 400, ok);
    total++;
    if (get_w(r) !== 32'h0F00_0F00 || lens[r] != LowLen) begin
      bad++;
      $display("FAIL reinit_first: got %h len %0d want 0f000f00 len %0d", get_w(r), lens[r],
               LowLen);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frames();
    test_snapshot();
    test_intensity();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
